// File: rtl/tiled_matrix_multiplier.sv
// ---------------------------------------------------------------------------
// tiled_matrix_multiplier
//
// Computes C = A x B for square N x N matrices held in internal register
// arrays. P MAC lanes each produce one output column per pass; passes sweep
// the column groups of a row, then move on to the next row. A and B are
// loaded over clocked write ports and C is read back over a registered port.
//
// Optional feature: define TMM_SATURATE_EN to clamp every accumulate step to
// the ACC_W range and raise the sticky sat_flag. Without the macro the
// accumulators wrap modulo 2^ACC_W and sat_flag is tied low.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a computation (honoured only when idle)
//   a_we/a_i/a_j    A write enable, row, column
//   a_in            A write data
//   b_we/b_i/b_j    B write enable, row, column
//   b_in            B write data
//   z_i/z_j         C read row, column
//   z_out           C read data, registered (0 for out-of-range indices)
//   busy            computation in progress
//   done            one-cycle completion pulse
//   sat_flag        sticky saturation indicator
// ---------------------------------------------------------------------------
module tiled_matrix_multiplier #(
  parameter int N      = 4,
  parameter int P      = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SIGNED = 1,
  parameter int IDX_W  = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_we,
  input  logic [IDX_W-1:0]  a_i,
  input  logic [IDX_W-1:0]  a_j,
  input  logic [DATA_W-1:0] a_in,
  input  logic              b_we,
  input  logic [IDX_W-1:0]  b_i,
  input  logic [IDX_W-1:0]  b_j,
  input  logic [DATA_W-1:0] b_in,
  input  logic [IDX_W-1:0]  z_i,
  input  logic [IDX_W-1:0]  z_j,
  output logic [ACC_W-1:0]  z_out,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  localparam int G = (N + P - 1) / P;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(G - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  state_t state_q;

  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] grp_q;
  logic [IDX_W-1:0] k_q;
  logic             busy_q;
  logic             done_q;
  logic [ACC_W-1:0] zOut_q;

  logic [DATA_W-1:0] aMem [N][N];
  logic [DATA_W-1:0] bMem [N][N];
  logic [ACC_W-1:0]  cMem [N][N];

  logic [ACC_W-1:0]    acc_q   [P];
  logic [ACC_W-1:0]    acc_d   [P];
  logic [ACC_W-1:0]    accBase [P];
  logic [IDX_W-1:0]    laneCol [P];
  logic                laneValid [P];
  logic [DATA_W-1:0]   aOp;
  logic [2*DATA_W-1:0] aExt;
  logic [DATA_W-1:0]   bOp     [P];
  logic [2*DATA_W-1:0] bExt    [P];
  logic [2*DATA_W-1:0] prod    [P];
  logic [ACC_W-1:0]    prodExt [P];

`ifdef TMM_SATURATE_EN
  logic [ACC_W:0] sumWide [P];
  logic           satHit  [P];
  logic           satFlag_q;
`endif

  assign z_out = zOut_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef TMM_SATURATE_EN
  assign sat_flag = satFlag_q;
`else
  assign sat_flag = 1'b0;
`endif

  // Host write ports. Both matrices can be written on the same edge; writes
  // are dropped while a computation runs or when an index is out of range.
  always_ff @(posedge clk) begin
    if (a_we && !busy_q && (int'(a_i) < N) && (int'(a_j) < N)) begin
      aMem[a_i][a_j] <= a_in;
    end
    if (b_we && !busy_q && (int'(b_i) < N) && (int'(b_j) < N)) begin
      bMem[b_i][b_j] <= b_in;
    end
  end

  // Lane l of the current group owns column grp*P+l. When N is not a
  // multiple of P the last group has lanes past the matrix edge; those are
  // marked invalid so they never write C or raise the saturation flag.
  always_comb begin
    for (int l = 0; l < P; l++) begin
      laneValid[l] = (int'(grp_q) * P + l) < N;
      laneCol[l]   = laneValid[l] ? IDX_W'(int'(grp_q) * P + l) : '0;
    end
  end

  // One MAC step per lane. The product is formed at 2*DATA_W bits after
  // extending both operands to that width, which gives the correct low bits
  // for both signed and unsigned operands. It is then extended to ACC_W and
  // added to the running sum, which restarts from zero when k is 0.
  always_comb begin
    aOp = aMem[row_q][k_q];
    if (SIGNED != 0) begin
      aExt = (2*DATA_W)'($signed(aOp));
    end else begin
      aExt = (2*DATA_W)'(aOp);
    end
    for (int l = 0; l < P; l++) begin
      bOp[l] = bMem[k_q][laneCol[l]];
      if (SIGNED != 0) begin
        bExt[l] = (2*DATA_W)'($signed(bOp[l]));
      end else begin
        bExt[l] = (2*DATA_W)'(bOp[l]);
      end
      prod[l] = aExt * bExt[l];
      if (SIGNED != 0) begin
        prodExt[l] = ACC_W'($signed(prod[l]));
      end else begin
        prodExt[l] = ACC_W'(prod[l]);
      end
      accBase[l] = (k_q == '0) ? '0 : acc_q[l];
`ifdef TMM_SATURATE_EN
      // One guard bit exposes overflow: for signed sums the two top bits
      // disagree, for unsigned sums the carry is set.
      satHit[l] = 1'b0;
      if (SIGNED != 0) begin
        sumWide[l] = {accBase[l][ACC_W-1], accBase[l]} + {prodExt[l][ACC_W-1], prodExt[l]};
        if (sumWide[l][ACC_W] != sumWide[l][ACC_W-1]) begin
          satHit[l] = laneValid[l];
          acc_d[l]  = sumWide[l][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          acc_d[l] = sumWide[l][ACC_W-1:0];
        end
      end else begin
        sumWide[l] = {1'b0, accBase[l]} + {1'b0, prodExt[l]};
        if (sumWide[l][ACC_W]) begin
          satHit[l] = laneValid[l];
          acc_d[l]  = {ACC_W{1'b1}};
        end else begin
          acc_d[l] = sumWide[l][ACC_W-1:0];
        end
      end
`else
      acc_d[l] = accBase[l] + prodExt[l];
`endif
    end
  end

  // Control FSM with registered status outputs and the C read port. Each
  // row/group pass spends N cycles accumulating and one cycle writing back,
  // so busy stays high for N*G*(N+1) cycles. Storage is left untouched by
  // reset; only control state and outputs are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zOut_q  <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      k_q     <= '0;
`ifdef TMM_SATURATE_EN
      satFlag_q <= 1'b0;
`endif
    end else begin
      if ((int'(z_i) < N) && (int'(z_j) < N)) begin
        zOut_q <= cMem[z_i][z_j];
      end else begin
        zOut_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= MAC;
            busy_q  <= 1'b1;
            row_q   <= '0;
            grp_q   <= '0;
            k_q     <= '0;
`ifdef TMM_SATURATE_EN
            satFlag_q <= 1'b0;
`endif
          end
        end

        MAC: begin
          for (int l = 0; l < P; l++) begin
            acc_q[l] <= acc_d[l];
`ifdef TMM_SATURATE_EN
            if (satHit[l]) begin
              satFlag_q <= 1'b1;
            end
`endif
          end
          if (k_q == LAST_IDX) begin
            k_q     <= '0;
            state_q <= WRITE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end

        WRITE: begin
          for (int l = 0; l < P; l++) begin
            if (laneValid[l]) begin
              cMem[row_q][laneCol[l]] <= acc_q[l];
            end
          end
          if (grp_q == LAST_GRP) begin
            grp_q <= '0;
            if (row_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= MAC;
            end
          end else begin
            grp_q   <= grp_q + 1'b1;
            state_q <= MAC;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// ---------------------------------------------------------------------------
// tb_tiled_matrix_multiplier
//
// Self-checking bench for tiled_matrix_multiplier. Two instances share the
// clock and reset: a default 4x4 build (ACC_W=40) and a 5x5 build with
// ACC_W=32, which exercises an uneven last column group and narrow
// accumulators. Expected C values come from a plain dot-product reference
// model with optional per-step clamping when TMM_SATURATE_EN is defined.
// ---------------------------------------------------------------------------
module tb_tiled_matrix_multiplier;

  typedef int mat_t [5][5];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start4 = 1'b0, aWe4 = 1'b0, bWe4 = 1'b0;
  logic [1:0]  ai4 = '0, aj4 = '0, bi4 = '0, bj4 = '0, zi4 = '0, zj4 = '0;
  logic [15:0] aIn4 = '0, bIn4 = '0;
  logic [39:0] zOut4;
  logic        busy4, done4, sat4;

  logic        start5 = 1'b0, aWe5 = 1'b0, bWe5 = 1'b0;
  logic [2:0]  ai5 = '0, aj5 = '0, bi5 = '0, bj5 = '0, zi5 = '0, zj5 = '0;
  logic [15:0] aIn5 = '0, bIn5 = '0;
  logic [31:0] zOut5;
  logic        busy5, done5, sat5;

  mat_t mA4, mB4, mA5, mB5;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  tiled_matrix_multiplier #(.N(4), .P(2), .DATA_W(16), .ACC_W(40), .SIGNED(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a_we(aWe4), .a_i(ai4), .a_j(aj4), .a_in(aIn4),
    .b_we(bWe4), .b_i(bi4), .b_j(bj4), .b_in(bIn4),
    .z_i(zi4), .z_j(zj4), .z_out(zOut4),
    .busy(busy4), .done(done4), .sat_flag(sat4)
  );

  tiled_matrix_multiplier #(.N(5), .P(2), .DATA_W(16), .ACC_W(32), .SIGNED(1)) dut5 (
    .clk(clk), .rst(rst), .start(start5),
    .a_we(aWe5), .a_i(ai5), .a_j(aj5), .a_in(aIn5),
    .b_we(bWe5), .b_i(bi5), .b_j(bj5), .b_in(bIn5),
    .z_i(zi5), .z_j(zj5), .z_out(zOut5),
    .busy(busy5), .done(done5), .sat_flag(sat5)
  );

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], clamped after every step to
  // the signed accw range when saturation is enabled. Wrapping is left to
  // the caller's truncation to accw bits.
  function automatic longint modelElem(input mat_t a, input mat_t b, input int n,
                                       input int i, input int j, input int accw,
                                       output bit sat);
    longint acc  = 0;
    longint maxV = (longint'(1) <<< (accw - 1)) - 1;
    longint minV = -maxV - 1;
    sat = 1'b0;
    for (int k = 0; k < n; k++) begin
      acc = acc + longint'(a[i][k]) * longint'(b[k][j]);
`ifdef TMM_SATURATE_EN
      if (acc > maxV) begin
        acc = maxV;
        sat = 1'b1;
      end else if (acc < minV) begin
        acc = minV;
        sat = 1'b1;
      end
`endif
    end
    return acc;
  endfunction

  function automatic int randElem();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- driver helpers (no checking inside) ----------------

  task automatic load4();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        aWe4 = 1'b1; ai4 = 2'(i); aj4 = 2'(j); aIn4 = 16'(mA4[i][j]);
        bWe4 = 1'b1; bi4 = 2'(i); bj4 = 2'(j); bIn4 = 16'(mB4[i][j]);
      end
    end
    @(negedge clk);
    aWe4 = 1'b0; bWe4 = 1'b0;
  endtask

  task automatic load5();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        aWe5 = 1'b1; ai5 = 3'(i); aj5 = 3'(j); aIn5 = 16'(mA5[i][j]);
        bWe5 = 1'b1; bi5 = 3'(i); bj5 = 3'(j); bIn5 = 16'(mB5[i][j]);
      end
    end
    @(negedge clk);
    aWe5 = 1'b0; bWe5 = 1'b0;
  endtask

  // Starts a run and counts the cycles busy is seen high. If injectAt > 0,
  // a start pulse and an A[0][0]=0x7FFF write are driven on that busy cycle.
  task automatic run4(input int injectAt, output int cycles, output logic doneEnd,
                      output logic doneNext);
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cycles = 0;
    while (busy4 === 1'b1 && cycles < 1000) begin
      cycles++;
      if (cycles == injectAt) begin
        start4 = 1'b1; aWe4 = 1'b1; ai4 = 2'd0; aj4 = 2'd0; aIn4 = 16'h7FFF;
      end else begin
        start4 = 1'b0; aWe4 = 1'b0;
      end
      @(negedge clk);
    end
    start4 = 1'b0; aWe4 = 1'b0;
    doneEnd = done4;
    @(negedge clk);
    doneNext = done4;
  endtask

  task automatic run5(output int cycles, output logic doneEnd, output logic doneNext);
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    cycles = 0;
    while (busy5 === 1'b1 && cycles < 1000) begin
      cycles++;
      @(negedge clk);
    end
    doneEnd = done5;
    @(negedge clk);
    doneNext = done5;
  endtask

  task automatic read4(input int i, input int j, output logic [39:0] val);
    @(negedge clk);
    zi4 = 2'(i); zj4 = 2'(j);
    @(negedge clk);
    val = zOut4;
  endtask

  task automatic read5(input int i, input int j, output logic [31:0] val);
    @(negedge clk);
    zi5 = 3'(i); zj5 = 3'(j);
    @(negedge clk);
    val = zOut5;
  endtask

  // ---------------- scenarios ----------------

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assertCount++;
    if (busy4 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy4 got=%b want=0", busy4); end
    assertCount++;
    if (done4 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done4 got=%b want=0", done4); end
    assertCount++;
    if (sat4 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_sat4 got=%b want=0", sat4); end
    assertCount++;
    if (zOut4 !== 40'd0) begin failCount++; $display("[TB] FAIL reset_zout4 got=%h want=0", zOut4); end
    assertCount++;
    if (busy5 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy5 got=%b want=0", busy5); end
    assertCount++;
    if (zOut5 !== 32'd0) begin failCount++; $display("[TB] FAIL reset_zout5 got=%h want=0", zOut5); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all4(input string tag);
    logic [39:0] got, exp;
    bit s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        read4(i, j, got);
        exp = 40'(modelElem(mA4, mB4, 4, i, j, 40, s));
        assertCount++;
        if (got !== exp) begin
          failCount++;
          $display("[TB] FAIL %s C[%0d][%0d] got=%h want=%h", tag, i, j, got, exp);
        end
      end
    end
  endtask

  task automatic test_identity();
    int cyc;
    logic dEnd, dNext;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA4[i][j] = (i == j) ? 1 : 0;
        mB4[i][j] = 10 * i + j;
      end
    load4();
    run4(0, cyc, dEnd, dNext);
    assertCount++;
    if (cyc != 4 * 2 * 5) begin failCount++; $display("[TB] FAIL identity_busy_cycles got=%0d want=%0d", cyc, 40); end
    assertCount++;
    if (dEnd !== 1'b1) begin failCount++; $display("[TB] FAIL identity_done_pulse got=%b want=1", dEnd); end
    assertCount++;
    if (dNext !== 1'b0) begin failCount++; $display("[TB] FAIL identity_done_clear got=%b want=0", dNext); end
    check_all4("identity");
  endtask

  task automatic test_signed_const();
    int cyc;
    logic dEnd, dNext;
    logic [39:0] got;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA4[i][j] = -3;
        mB4[i][j] = 5;
      end
    load4();
    run4(0, cyc, dEnd, dNext);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        read4(i, j, got);
        assertCount++;
        if (got !== 40'hFFFFFFFFC4) begin
          failCount++;
          $display("[TB] FAIL signed_const C[%0d][%0d] got=%h want=FFFFFFFFC4", i, j, got);
        end
      end
  endtask

  task automatic test_random();
    int cyc;
    logic dEnd, dNext;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          mA4[i][j] = randElem();
          mB4[i][j] = randElem();
        end
      load4();
      run4(0, cyc, dEnd, dNext);
      assertCount++;
      if (cyc != 40) begin failCount++; $display("[TB] FAIL random_busy_cycles got=%0d want=40", cyc); end
      check_all4("random");
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    logic dEnd, dNext;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA4[i][j] = randElem();
        mB4[i][j] = randElem();
      end
    mA4[0][0] = 1234;
    load4();
    run4(5, cyc, dEnd, dNext);
    assertCount++;
    if (cyc != 40) begin failCount++; $display("[TB] FAIL busy_ignore_cycles got=%0d want=40", cyc); end
    assertCount++;
    if (dEnd !== 1'b1) begin failCount++; $display("[TB] FAIL busy_ignore_done got=%b want=1", dEnd); end
    check_all4("busy_ignore");
    // A second run on the same data must still see the pre-load A.
    run4(0, cyc, dEnd, dNext);
    check_all4("busy_ignore_rerun");
  endtask

  task automatic test_start_in_done();
    int cyc = 0;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (busy4 === 1'b1 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    assertCount++;
    if (done4 !== 1'b1) begin failCount++; $display("[TB] FAIL done_state_pulse got=%b want=1", done4); end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    assertCount++;
    if (busy4 !== 1'b0) begin failCount++; $display("[TB] FAIL start_in_done_busy got=%b want=0", busy4); end
    assertCount++;
    if (done4 !== 1'b0) begin failCount++; $display("[TB] FAIL start_in_done_done got=%b want=0", done4); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic dEnd, dNext;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA4[i][j] = randElem();
        mB4[i][j] = randElem();
      end
    load4();
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    assertCount++;
    if (busy4 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mid_busy got=%b want=0", busy4); end
    assertCount++;
    if (done4 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mid_done got=%b want=0", done4); end
    run4(0, cyc, dEnd, dNext);
    assertCount++;
    if (cyc != 40) begin failCount++; $display("[TB] FAIL reset_mid_restart_cycles got=%0d want=40", cyc); end
    check_all4("reset_mid");
  endtask

  task automatic test_uneven_groups();
    int cyc;
    logic dEnd, dNext;
    logic [31:0] got, exp;
    bit s;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        mA5[i][j] = randElem();
        mB5[i][j] = randElem();
      end
    load5();
    run5(cyc, dEnd, dNext);
    assertCount++;
    if (cyc != 5 * 3 * 6) begin failCount++; $display("[TB] FAIL n5_busy_cycles got=%0d want=90", cyc); end
    assertCount++;
    if (dEnd !== 1'b1) begin failCount++; $display("[TB] FAIL n5_done_pulse got=%b want=1", dEnd); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        read5(i, j, got);
        exp = 32'(modelElem(mA5, mB5, 5, i, j, 32, s));
        assertCount++;
        if (got !== exp) begin
          failCount++;
          $display("[TB] FAIL n5 C[%0d][%0d] got=%h want=%h", i, j, got, exp);
        end
      end
    read5(2, 5, got);
    assertCount++;
    if (got !== 32'd0) begin failCount++; $display("[TB] FAIL n5_read_col5 got=%h want=0", got); end
    read5(6, 1, got);
    assertCount++;
    if (got !== 32'd0) begin failCount++; $display("[TB] FAIL n5_read_row6 got=%h want=0", got); end
  endtask

  task automatic test_saturation();
    int cyc;
    logic dEnd, dNext;
    logic [31:0] got, exp;
    bit s;
    bit anySat = 1'b0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        mA5[i][j] = -32768;
        mB5[i][j] = -32768;
      end
    load5();
    run5(cyc, dEnd, dNext);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        read5(i, j, got);
        exp = 32'(modelElem(mA5, mB5, 5, i, j, 32, s));
        anySat = anySat | s;
        assertCount++;
        if (got !== exp) begin
          failCount++;
          $display("[TB] FAIL sat C[%0d][%0d] got=%h want=%h", i, j, got, exp);
        end
      end
    assertCount++;
    if (sat5 !== anySat) begin failCount++; $display("[TB] FAIL sat_flag got=%b want=%b", sat5, anySat); end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        mA5[i][j] = 1;
        mB5[i][j] = 1;
      end
    load5();
    assertCount++;
    if (sat5 !== anySat) begin failCount++; $display("[TB] FAIL sat_flag_sticky got=%b want=%b", sat5, anySat); end
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    assertCount++;
    if (sat5 !== 1'b0) begin failCount++; $display("[TB] FAIL sat_flag_clear_on_start got=%b want=0", sat5); end
    cyc = 0;
    while (busy5 === 1'b1 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    read5(4, 4, got);
    assertCount++;
    if (got !== 32'd5) begin failCount++; $display("[TB] FAIL sat_followup C[4][4] got=%h want=5", got); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed_const();
    test_random();
    test_busy_ignore();
    test_start_in_done();
    test_reset_mid();
    test_uneven_groups();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
